// File: rtl/regwrite_sched.sv
// regwrite_sched: shares the register-file write port between pipeline
// writeback and a long-latency result unit, and keeps a scoreboard of
// destinations with results still in flight so decode can stall on them.
module regwrite_sched #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        wb_hold,
    input  logic        lu_valid,
    input  logic [4:0]  lu_addr,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    input  logic        iss_valid,
    input  logic [4:0]  iss_addr,
    input  logic [4:0]  dec_rs,
    input  logic [4:0]  dec_rt,
    input  logic [4:0]  dec_rd,
    output logic        stall,
    output logic        regwrite,
    output logic [4:0]  write,
    output logic [31:0] writedata,
    output logic        err
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    // Bit 0 is kept at zero so that address 0 never looks pending.
    logic [31:0]      pending_q, pending_d;
    logic             buf_full_q, buf_full_d;
    logic [4:0]       buf_addr_q, buf_addr_d;
    logic [31:0]      buf_data_q, buf_data_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             err_q, err_d;

    logic drain;
    logic accept;

    // Write-port mux, handshake and hazard detection; writeback always wins.
    always_comb begin
        drain     = buf_full_q & ~wb_we;
        lu_ready  = ~buf_full_q | ~wb_we;
        accept    = lu_valid & lu_ready;
        regwrite  = rst_n & (wb_we | buf_full_q);
        write     = wb_we ? wb_addr : buf_addr_q;
        writedata = wb_we ? wb_data : buf_data_q;
        wb_hold   = buf_full_q & (starve_cnt_q == CNT_W'(STARVE_MAX));
        stall     = pending_q[dec_rs] | pending_q[dec_rt] | pending_q[dec_rd];
        err       = err_q;
    end

    // Next-state: buffer reload/drain, scoreboard set-over-clear, starvation age, sticky error.
    always_comb begin
        buf_full_d = buf_full_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        if (drain) begin
            buf_full_d = 1'b0;
        end
        if (accept) begin
            buf_full_d = 1'b1;
            buf_addr_d = lu_addr;
            buf_data_d = lu_data;
        end

        pending_d = pending_q;
        if (drain) begin
            pending_d[buf_addr_q] = 1'b0;
        end
        if (iss_valid && (iss_addr != 5'd0)) begin
            pending_d[iss_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;

        starve_cnt_d = '0;
        if (buf_full_q && wb_we) begin
            if (starve_cnt_q != CNT_W'(STARVE_MAX)) begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end else begin
                starve_cnt_d = starve_cnt_q;
            end
        end

        err_d = err_q;
        if (accept && (lu_addr != 5'd0) && !pending_q[lu_addr]) begin
            err_d = 1'b1;
        end
        if (wb_we && pending_q[wb_addr]) begin
            err_d = 1'b1;
        end
        if (wb_we && wb_hold) begin
            err_d = 1'b1;
        end
    end

    // State registers; reset discards any buffered result and all pending bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q    <= '0;
            buf_full_q   <= 1'b0;
            buf_addr_q   <= '0;
            buf_data_q   <= '0;
            starve_cnt_q <= '0;
            err_q        <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            buf_full_q   <= buf_full_d;
            buf_addr_q   <= buf_addr_d;
            buf_data_q   <= buf_data_d;
            starve_cnt_q <= starve_cnt_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_regwrite_sched.sv
// Bench for regwrite_sched: directed scenarios plus randomized compliant
// traffic, all checked cycle by cycle against a queue-based reference model.
module tb_regwrite_sched;

    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        wb_hold;
    logic        lu_valid = 1'b0;
    logic [4:0]  lu_addr = '0;
    logic [31:0] lu_data = '0;
    logic        lu_ready;
    logic        iss_valid = 1'b0;
    logic [4:0]  iss_addr = '0;
    logic [4:0]  dec_rs = '0;
    logic [4:0]  dec_rt = '0;
    logic [4:0]  dec_rd = '0;
    logic        stall;
    logic        regwrite;
    logic [4:0]  write;
    logic [31:0] writedata;
    logic        err;

    always #5 clk = ~clk;

    regwrite_sched #(.STARVE_MAX(SM)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .wb_hold(wb_hold),
        .lu_valid(lu_valid), .lu_addr(lu_addr), .lu_data(lu_data), .lu_ready(lu_ready),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_rd(dec_rd), .stall(stall),
        .regwrite(regwrite), .write(write), .writedata(writedata), .err(err)
    );

    // Reference model: set of outstanding registers, a queue holding at most
    // one waiting result, and the number of cycles that result has been blocked.
    bit          pend [32];
    logic [4:0]  bq_addr [$];
    logic [31:0] bq_data [$];
    int          blocked;
    bit          m_err;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit m_hold();
        return (bq_addr.size() != 0) && (blocked >= SM);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) pend[i] = 1'b0;
        bq_addr.delete();
        bq_data.delete();
        blocked = 0;
        m_err = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h5a5a5a5a;
        lu_valid = 1'b0; iss_valid = 1'b0;
        dec_rs = 5'd5; dec_rt = 5'd7; dec_rd = 5'd9;
        #1;
        model_clear();
        chk("rst_regwrite", {31'd0, regwrite}, 32'd0);
        chk("rst_lu_ready", {31'd0, lu_ready}, 32'd1);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_wb_hold", {31'd0, wb_hold}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        wb_we = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic lv, input logic [4:0] la, input logic [31:0] ld,
                        input logic iv, input logic [4:0] ia,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        bit full, e_ready, e_stall, e_hold, acc;
        @(negedge clk);
        wb_we = we; wb_addr = wa; wb_data = wd;
        lu_valid = lv; lu_addr = la; lu_data = ld;
        iss_valid = iv; iss_addr = ia;
        dec_rs = rs; dec_rt = rt; dec_rd = rd;
        #1;
        full    = (bq_addr.size() != 0);
        e_ready = !full || !we;
        e_stall = (rs != 0 && pend[rs]) || (rt != 0 && pend[rt]) || (rd != 0 && pend[rd]);
        e_hold  = m_hold();
        chk("regwrite", {31'd0, regwrite}, {31'd0, (we | full)});
        if (we || full) begin
            chk("write", {27'd0, write}, {27'd0, (we ? wa : bq_addr[0])});
            chk("writedata", writedata, we ? wd : bq_data[0]);
        end
        chk("lu_ready", {31'd0, lu_ready}, {31'd0, e_ready});
        chk("stall", {31'd0, stall}, {31'd0, e_stall});
        chk("wb_hold", {31'd0, wb_hold}, {31'd0, e_hold});
        chk("err", {31'd0, err}, {31'd0, m_err});
        @(posedge clk);
        acc = lv && e_ready;
        if (acc && la != 0 && !pend[la]) m_err = 1'b1;
        if (we && wa != 0 && pend[wa]) m_err = 1'b1;
        if (we && e_hold) m_err = 1'b1;
        blocked = (full && we) ? ((blocked < SM) ? blocked + 1 : SM) : 0;
        if (full && !we) begin
            pend[bq_addr[0]] = 1'b0;
            void'(bq_addr.pop_front());
            void'(bq_data.pop_front());
        end
        if (acc) begin
            bq_addr.push_back(la);
            bq_data.push_back(ld);
        end
        if (iv && ia != 0) pend[ia] = 1'b1;
        pend[0] = 1'b0;
        #1;
    endtask

    task automatic idle(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, rs, rt, rd);
    endtask

    task automatic issue(input logic [4:0] ia);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, ia, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic ret(input logic [4:0] la, input logic [31:0] ld);
        step(1'b0, 5'd0, 32'd0, 1'b1, la, ld, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
    endtask

    initial begin
        int cand [$];
        logic        r_we, r_lv, r_iv;
        logic [4:0]  r_wa, r_la, r_ia;
        model_clear();

        // Reset and first hazard
        do_reset();
        issue(5'd5);
        idle(5'd5, 5'd0, 5'd0);
        chk("stall_r5", {31'd0, stall}, 32'd1);
        idle(5'd0, 5'd0, 5'd0);
        chk("stall_r0", {31'd0, stall}, 32'd0);

        // Basic return of r5
        ret(5'd5, 32'hDEADBEEF);
        chk("basic_regwrite", {31'd0, regwrite}, 32'd1);
        chk("basic_wdata", writedata, 32'hDEADBEEF);
        chk("basic_waddr", {27'd0, write}, 32'd5);
        idle(5'd0, 5'd5, 5'd0);
        idle(5'd0, 5'd5, 5'd0);
        chk("basic_stall_clear", {31'd0, stall}, 32'd0);

        // Contention: buffered r6 blocked by writeback to r3
        issue(5'd6);
        ret(5'd6, 32'h00000066);
        for (int i = 0; i < SM; i++)
            step(1'b1, 5'd3, 32'h11, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd6, 5'd0, 5'd0);
        chk("contend_hold", {31'd0, wb_hold}, 32'd1);
        idle(5'd0, 5'd0, 5'd0);
        chk("contend_hold_drop", {31'd0, wb_hold}, 32'd0);
        chk("contend_err", {31'd0, err}, 32'd0);

        // Back-to-back returns
        issue(5'd7);
        issue(5'd8);
        ret(5'd7, 32'h77770007);
        chk("b2b_wdata7", writedata, 32'h77770007);
        ret(5'd8, 32'h88880008);
        chk("b2b_wdata8", writedata, 32'h88880008);
        idle(5'd7, 5'd8, 5'd0);

        // Drain of r9 coinciding with a new issue to r9
        issue(5'd9);
        ret(5'd9, 32'h99);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd0, 5'd0, 5'd9);
        idle(5'd0, 5'd0, 5'd9);
        chk("setclr_stall", {31'd0, stall}, 32'd1);

        // Randomized compliant traffic
        for (int c = 0; c < 400; c++) begin
            cand.delete();
            for (int a = 1; a < 32; a++) if (pend[a]) cand.push_back(a);
            r_wa = 5'($urandom_range(0, 31));
            r_we = ($urandom_range(0, 2) != 0) && !m_hold() && !pend[r_wa];
            r_lv = (cand.size() != 0) && ($urandom_range(0, 1) == 1);
            r_la = (cand.size() != 0) ? 5'(cand[$urandom_range(0, cand.size() - 1)]) : 5'd0;
            r_iv = ($urandom_range(0, 3) == 0);
            r_ia = 5'($urandom_range(0, 31));
            step(r_we, r_wa, $urandom, r_lv, r_la, $urandom, r_iv, r_ia,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        // Error: result for a register that is not pending
        do_reset();
        ret(5'd12, 32'h12);
        chk("err_nonpending", {31'd0, err}, 32'd1);
        idle(5'd0, 5'd0, 5'd0);
        idle(5'd0, 5'd0, 5'd0);
        chk("err_sticky1", {31'd0, err}, 32'd1);

        // Error: writeback to a pending register
        do_reset();
        issue(5'd4);
        step(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0, 5'd0);
        chk("err_wb_pending", {31'd0, err}, 32'd1);
        idle(5'd0, 5'd0, 5'd0);
        chk("err_sticky2", {31'd0, err}, 32'd1);
        do_reset();
        idle(5'd0, 5'd0, 5'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
